pwm_sequencer: RTL and testbench
================================

PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 SHALL have parameter: CNT_WIDTH, 16, width of the carrier counter, period and duty.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: start, stop  input  1 each  single-cycle command pulses.
REQ-005 SHALL have ports: cfg_valid input 1, cfg_ready output 1  handshake that writes the shadow configuration.
REQ-006 SHALL have ports: period_in, duty_in  input  CNT_WIDTH each  carrier period and compare value, in clk cycles.
REQ-007 SHALL have ports: dtime_A_in, dtime_B_in  input  `DTCOUNT_WIDTH+1 each  requested dead times.
REQ-008 SHALL have ports: fault, fault_clr  input  1 each  fault request (asynchronous) and fault clear pulse.
REQ-009 SHALL have ports: pwm  output  1  raw PWM driven into the dead-time stage.
REQ-010 SHALL have ports: dtime_A, dtime_B  output  `DTCOUNT_WIDTH+1 each  active dead times.
REQ-011 SHALL have ports: pwm_onoff  output  _pwm_onoff  dead-time stage enable.
REQ-012 SHALL have ports: period_end  output  1, cfg_err  output  1, fault_active  output  1  status pulses and flags.

Function
REQ-013 SHALL implement FSM IDLE, ARM, RUN, DRAIN, FAULT; FAULT is reachable only when the fault feature is compiled in.
REQ-014 SHALL accept a cfg write when cfg_valid && cfg_ready; cfg_ready SHALL equal ~pending.
REQ-015 SHALL treat a write with period_in < 2 as rejected: shadow unchanged, pending unchanged, cfg_err high for exactly 1 cycle.
REQ-016 SHALL set pending and "configured" on an accepted write; the write takes effect at the next ARM or period boundary, never in the cycle it is accepted.
REQ-017 SHALL in IDLE move to ARM on start when configured; SHALL ignore start when unconfigured or when not in IDLE; stop and start in the same IDLE cycle SHALL mean stay in IDLE.
REQ-018 SHALL in ARM (1 cycle) copy shadow to the active registers, clear pending, zero the counter, and drive pwm_onoff ON from the next cycle.
REQ-019 SHALL in RUN count 0..period-1 and wrap; pwm SHALL be registered as (counter < duty); duty=0 gives constant 0 and duty >= period gives constant 1.
REQ-020 SHALL pulse period_end in the cycle counter == period-1; on that cycle, if pending, SHALL load the active registers from the shadow and clear pending.
REQ-021 SHALL latch stop in RUN and enter DRAIN at the next period_end, never mid-period.
REQ-022 SHALL in DRAIN force pwm=0 for dtime_A+2 cycles, then drive pwm_onoff OFF and go to IDLE.
REQ-023 SHALL keep dtime_A and dtime_B stable except at the ARM or period-boundary load.

Reset
REQ-024 SHALL on reset, at any time including mid-RUN, force: state IDLE, pwm 0, pwm_onoff OFF, dtime_A and dtime_B 0, counter 0, pending 0, configured 0, cfg_ready 1, period_end 0, cfg_err 0, fault_active 0.

Configuration
REQ-025 SHALL, with PWM_FAULT_EN defined: synchronize fault through 2 flops. A synchronized fault in ARM, RUN or DRAIN SHALL drive pwm_onoff OFF and pwm 0 on the next edge and enter FAULT, with fault_active high. FAULT SHALL exit to IDLE only on fault_clr while the synchronized fault is low.
REQ-026 SHALL, without PWM_FAULT_EN: keep the ports present, ignore fault and fault_clr, and tie fault_active to 0.

Structure
REQ-027 SHALL take _pwm_onoff, `DTCOUNT_WIDTH and a new state enum typedef _pwm_seq_state from PKG_pwm.
REQ-028 SHALL use one sub-module, pwm_carrier: the counter, compare and period_end logic.

Verification
REQ-029 SHALL cover: cfg period=10, duty=3, dt=2/2, start -> pwm pattern 3 high / 7 low repeating, period_end every 10 cycles, pwm_onoff ON 2 cycles after start.
REQ-030 SHALL cover: new duty=7 written mid-period -> old duty holds until period_end; new duty applies from the next period; cfg_ready stays low until the load.
REQ-031 SHALL cover: cfg period_in=1 -> cfg_err 1-cycle pulse, shadow unchanged; duty=0 -> pwm constant 0; duty=12 with period=10 -> pwm constant 1.
REQ-032 SHALL cover: stop at counter=4, dtime_A=3 -> DRAIN entered at period end, pwm low 5 cycles, then pwm_onoff OFF and state IDLE.
REQ-033 SHALL cover: reset asserted mid-RUN -> all outputs at reset values immediately; start with no new cfg write is ignored.
REQ-034 SHALL cover, with PWM_FAULT_EN: fault pulse in RUN -> pwm_onoff OFF within 3 edges; fault_clr while fault high is ignored; fault_clr after fault low -> IDLE.

Source files
------------

// File: rtl/pwm_sequencer_pkg.sv
// Shared types for the PWM sequencer: dead-time stage enable, FSM state and dead-time width.
`ifndef DTCOUNT_WIDTH
`define DTCOUNT_WIDTH 4
`endif

package PKG_pwm;

    localparam int unsigned DT_W = `DTCOUNT_WIDTH + 1;

    typedef enum logic {
        PwmOff = 1'b0,
        PwmOn  = 1'b1
    } _pwm_onoff;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StRun,
        StDrain,
        StFault
    } _pwm_seq_state;

endpackage

// File: rtl/pwm_carrier.sv
// Carrier counter for the PWM sequencer: wraps at period-1, registered compare, period_end.
module pwm_carrier #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 run_next,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] duty_next,
    output logic                 pwm,
    output logic                 period_end
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pwm_q, pwm_d;
    logic                 wrap;

    assign wrap       = (cnt_q == period - CNT_WIDTH'(1));
    assign period_end = run && wrap;

    // pwm is computed from the next count and next duty so it lines up with cnt_q
    always_comb begin
        cnt_d = '0;
        if (run && !wrap) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        pwm_d = run_next && (cnt_d < duty_next);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_sequencer.sv
// PWM sequencer: shadowed configuration, start/stop/drain sequencing and a fault shutdown
// path that is compiled in only when PWM_FAULT_EN is defined.
module pwm_sequencer
    import PKG_pwm::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CNT_WIDTH-1:0]    period_in,
    input  logic [CNT_WIDTH-1:0]    duty_in,
    input  logic [`DTCOUNT_WIDTH:0] dtime_A_in,
    input  logic [`DTCOUNT_WIDTH:0] dtime_B_in,
    input  logic                    fault,
    input  logic                    fault_clr,
    output logic                    pwm,
    output logic [`DTCOUNT_WIDTH:0] dtime_A,
    output logic [`DTCOUNT_WIDTH:0] dtime_B,
    output _pwm_onoff               pwm_onoff,
    output logic                    period_end,
    output logic                    cfg_err,
    output logic                    fault_active
);

    localparam int unsigned DC_W = DT_W + 1;

    _pwm_seq_state        state_q, state_d;
    logic [CNT_WIDTH-1:0] sh_period_q, sh_duty_q, period_q, duty_q, duty_nxt;
    logic [DT_W-1:0]      sh_dta_q, sh_dtb_q, dta_q, dtb_q;
    logic [DC_W-1:0]      drain_cnt_q;
    logic                 pending_q, configured_q, stop_q, cfg_err_q;
    _pwm_onoff            onoff_q;
    logic                 cfg_hs, cfg_accept, cfg_reject;
    logic                 run, run_next, load, drain_done, carrier_end;
    logic                 fault_hit, fault_exit;

    assign cfg_hs     = cfg_valid && !pending_q;
    assign cfg_reject = cfg_hs && (period_in < CNT_WIDTH'(2));
    assign cfg_accept = cfg_hs && !cfg_reject;

`ifdef PWM_FAULT_EN
    logic fault_s1_q, fault_s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_s1_q <= 1'b0;
            fault_s2_q <= 1'b0;
        end else begin
            fault_s1_q <= fault;
            fault_s2_q <= fault_s1_q;
        end
    end

    assign fault_hit    = fault_s2_q;
    assign fault_exit   = fault_clr && !fault_s2_q;
    assign fault_active = (state_q == StFault);
`else
    logic unused_fault;
    assign unused_fault = fault ^ fault_clr;
    assign fault_hit    = 1'b0;
    assign fault_exit   = 1'b0;
    assign fault_active = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && !stop && configured_q) state_d = StArm;
            StArm:   state_d = StRun;
            StRun:   if (carrier_end && (stop_q || stop)) state_d = StDrain;
            StDrain: if (drain_done) state_d = StIdle;
            StFault: if (fault_exit) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (fault_hit && (state_q inside {StArm, StRun, StDrain})) begin
            state_d = StFault;
        end
    end

    always_comb begin
        load       = 1'b0;
        drain_done = 1'b0;
        unique case (state_q)
            StArm:   load = 1'b1;
            StRun:   load = carrier_end && pending_q;
            StDrain: drain_done = (drain_cnt_q == {1'b0, dta_q} + DC_W'(1));
            default: ;
        endcase
    end

    assign run      = (state_q == StRun);
    assign run_next = (state_d == StRun);
    assign duty_nxt = load ? sh_duty_q : duty_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_period_q  <= '0;
            sh_duty_q    <= '0;
            sh_dta_q     <= '0;
            sh_dtb_q     <= '0;
            period_q     <= '0;
            duty_q       <= '0;
            dta_q        <= '0;
            dtb_q        <= '0;
            pending_q    <= 1'b0;
            configured_q <= 1'b0;
            stop_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            drain_cnt_q  <= '0;
            onoff_q      <= PwmOff;
        end else begin
            cfg_err_q <= cfg_reject;
            if (cfg_accept) begin
                sh_period_q  <= period_in;
                sh_duty_q    <= duty_in;
                sh_dta_q     <= dtime_A_in;
                sh_dtb_q     <= dtime_B_in;
                configured_q <= 1'b1;
            end
            // accept only happens with pending low, so it never races a boundary load
            if (cfg_accept) begin
                pending_q <= 1'b1;
            end else if (load) begin
                pending_q <= 1'b0;
            end
            if (load) begin
                period_q <= sh_period_q;
                duty_q   <= sh_duty_q;
                dta_q    <= sh_dta_q;
                dtb_q    <= sh_dtb_q;
            end
            stop_q      <= (run && run_next) ? (stop_q || stop) : 1'b0;
            drain_cnt_q <= (state_q == StDrain && state_d == StDrain) ?
                           drain_cnt_q + DC_W'(1) : '0;
            onoff_q     <= (state_d == StRun || state_d == StDrain) ? PwmOn : PwmOff;
        end
    end

    pwm_carrier #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_carrier (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .run_next  (run_next),
        .period    (period_q),
        .duty_next (duty_nxt),
        .pwm       (pwm),
        .period_end(carrier_end)
    );

    assign period_end = carrier_end;
    assign cfg_ready  = ~pending_q;
    assign cfg_err    = cfg_err_q;
    assign dtime_A    = dta_q;
    assign dtime_B    = dtb_q;
    assign pwm_onoff  = onoff_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer: directed scenarios then random traffic, every cycle compared with a
// phase/period reference model. Fault behaviour is checked when PWM_FAULT_EN is defined.
`ifndef DTCOUNT_WIDTH
`define DTCOUNT_WIDTH 4
`endif

module tb_pwm_sequencer;
    import PKG_pwm::*;

    localparam int unsigned CW  = 16;
    localparam int unsigned DTW = `DTCOUNT_WIDTH + 1;
    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DRAIN = 3, M_FAULT = 4;

    logic           clk = 1'b0;
    logic           reset, start, stop, cfg_valid, cfg_ready, fault, fault_clr;
    logic [CW-1:0]  period_in, duty_in;
    logic [DTW-1:0] dtime_A_in, dtime_B_in, dtime_A, dtime_B;
    logic           pwm, period_end, cfg_err, fault_active;
    _pwm_onoff      pwm_onoff;

    int checks, failures;

    // reference model: operating mode, position in the current period, shadow/active config
    int m_mode, m_phase, m_per, m_duty, m_dta, m_dtb, m_drain;
    int m_sh_per, m_sh_duty, m_sh_dta, m_sh_dtb;
    bit m_pend, m_cfgd, m_stop, m_cfg_err, m_f1, m_f2;

    always #5 clk = ~clk;

    pwm_sequencer #(
        .CNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .period_in   (period_in),
        .duty_in     (duty_in),
        .dtime_A_in  (dtime_A_in),
        .dtime_B_in  (dtime_B_in),
        .fault       (fault),
        .fault_clr   (fault_clr),
        .pwm         (pwm),
        .dtime_A     (dtime_A),
        .dtime_B     (dtime_B),
        .pwm_onoff   (pwm_onoff),
        .period_end  (period_end),
        .cfg_err     (cfg_err),
        .fault_active(fault_active)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_phase = 0; m_per = 0; m_duty = 0; m_dta = 0; m_dtb = 0; m_drain = 0;
        m_sh_per = 0; m_sh_duty = 0; m_sh_dta = 0; m_sh_dtb = 0;
        m_pend = 0; m_cfgd = 0; m_stop = 0; m_cfg_err = 0; m_f1 = 0; m_f2 = 0;
    endtask

    task automatic model_step();
        bit hs, at_end, ld;
        int n_mode;
        hs     = cfg_valid && !m_pend;
        at_end = (m_mode == M_RUN) && (m_phase == m_per - 1);
        ld     = (m_mode == M_ARM) || (at_end && m_pend);
        n_mode = m_mode;
        if (ld) begin
            m_per = m_sh_per; m_duty = m_sh_duty; m_dta = m_sh_dta; m_dtb = m_sh_dtb;
            m_pend = 0;
        end
        case (m_mode)
            M_IDLE:  if (start && !stop && m_cfgd) n_mode = M_ARM;
            M_ARM:   begin n_mode = M_RUN; m_phase = 0; end
            M_RUN: begin
                m_stop = m_stop || stop;
                if (at_end) begin
                    m_phase = 0;
                    if (m_stop) begin n_mode = M_DRAIN; m_drain = m_dta + 2; end
                end else begin
                    m_phase++;
                end
            end
            M_DRAIN: begin m_drain--; if (m_drain == 0) n_mode = M_IDLE; end
            M_FAULT: if (fault_clr && !m_f2) n_mode = M_IDLE;
            default: n_mode = M_IDLE;
        endcase
`ifdef PWM_FAULT_EN
        if (m_f2 && (m_mode == M_ARM || m_mode == M_RUN || m_mode == M_DRAIN)) n_mode = M_FAULT;
        m_f2 = m_f1;
        m_f1 = fault;
`endif
        if (n_mode != M_RUN) begin m_stop = 0; m_phase = 0; end
        if (hs && period_in >= 2) begin
            m_sh_per = int'(period_in); m_sh_duty = int'(duty_in);
            m_sh_dta = int'(dtime_A_in); m_sh_dtb = int'(dtime_B_in);
            m_pend = 1; m_cfgd = 1;
        end
        m_cfg_err = hs && (period_in < 2);
        m_mode = n_mode;
    endtask

    task automatic compare_all();
        bit e_run;
        e_run = (m_mode == M_RUN);
        check("pwm", 32'(pwm), 32'(e_run && (m_phase < m_duty)));
        check("period_end", 32'(period_end), 32'(e_run && (m_phase == m_per - 1)));
        check("pwm_onoff", 32'(pwm_onoff == PwmOn), 32'(e_run || m_mode == M_DRAIN));
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        check("cfg_err", 32'(cfg_err), 32'(m_cfg_err));
        check("dtime_A", 32'(dtime_A), 32'(m_dta));
        check("dtime_B", 32'(dtime_B), 32'(m_dtb));
        check("fault_active", 32'(fault_active), 32'(m_mode == M_FAULT));
    endtask

    task automatic tick();
        if (reset) model_reset(); else model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_n(input int n);
        repeat (n) tick();
    endtask

    task automatic cfg_write(input int p, input int d, input int a, input int b);
        cfg_valid = 1'b1; period_in = CW'(p); duty_in = CW'(d);
        dtime_A_in = DTW'(a); dtime_B_in = DTW'(b);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while (!(m_mode == M_RUN && m_phase == ph) && k < 100) begin tick(); k++; end
        check("wait_phase_timeout", 32'(k < 100), 32'd1);
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin hi += int'(pwm); tick(); end
    endtask

    task automatic wait_off();
        int k;
        k = 0;
        while (pwm_onoff == PwmOn && k < 60) begin tick(); k++; end
        check("wait_off_timeout", 32'(k < 60), 32'd1);
    endtask

    initial begin
        int n, hi, pe, low, k;
        checks = 0; failures = 0;
        reset = 1'b1; start = 0; stop = 0; cfg_valid = 0; fault = 0; fault_clr = 0;
        period_in = '0; duty_in = '0; dtime_A_in = '0; dtime_B_in = '0;
        model_reset();
        run_n(2);
        reset = 1'b0;
        tick();
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_onoff", 32'(pwm_onoff == PwmOff), 32'd1);
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_dtime_A", 32'(dtime_A), 32'd0);

        // start before any configuration is ignored
        start = 1; tick(); start = 0; run_n(3);
        check("start_unconfigured", 32'(pwm_onoff == PwmOn), 32'd0);

        // period 10, duty 3: onoff two cycles after start, 3 high / 7 low
        cfg_write(10, 3, 2, 2);
        tick();
        start = 1; tick(); start = 0;
        n = 1;
        while (pwm_onoff != PwmOn && n < 8) begin tick(); n++; end
        check("onoff_delay", 32'(n), 32'd2);
        hi = 0; pe = 0;
        for (int i = 0; i < 10; i++) begin hi += int'(pwm); pe += int'(period_end); tick(); end
        check("duty3_high", 32'(hi), 32'd3);
        check("duty3_period_end", 32'(pe), 32'd1);
        run_n(10);

        // mid-period rewrite: old duty holds to the boundary, new duty afterwards
        wait_phase(4);
        cfg_write(10, 7, 3, 2);
        check("ready_low_after_write", 32'(cfg_ready), 32'd0);
        count_high(5, hi);
        check("old_duty_holds", 32'(hi), 32'd0);
        check("ready_after_load", 32'(cfg_ready), 32'd1);
        count_high(10, hi);
        check("new_duty7", 32'(hi), 32'd7);

        // rejected write, then duty extremes
        cfg_write(1, 5, 0, 0);
        check("cfg_err_pulse", 32'(cfg_err), 32'd1);
        tick();
        check("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
        check("reject_keeps_dtA", 32'(dtime_A), 32'd3);
        cfg_write(10, 0, 3, 2);
        wait_phase(9); tick();
        count_high(10, hi);
        check("duty0_const_low", 32'(hi), 32'd0);
        cfg_write(10, 12, 3, 2);
        wait_phase(9); tick();
        count_high(10, hi);
        check("duty12_const_high", 32'(hi), 32'd10);

        // stop at counter 4 with dtime_A 3: drain at period end, 5 low cycles, then off
        cfg_write(10, 3, 3, 2);
        wait_phase(9); tick();
        wait_phase(4);
        stop = 1; tick(); stop = 0;
        k = 0;
        while (!period_end && k < 20) begin tick(); k++; end
        check("stop_reaches_period_end", 32'(k < 20), 32'd1);
        n = 0; low = 1; k = 0;
        while (pwm_onoff == PwmOn && k < 20) begin
            tick(); k++;
            if (pwm_onoff == PwmOn) begin n++; low = low & int'(!pwm); end
        end
        check("drain_cycles", 32'(n), 32'd5);
        check("drain_pwm_low", 32'(low), 32'd1);

        // start and stop together in IDLE means stay
        start = 1; stop = 1; tick(); start = 0; stop = 0; run_n(3);
        check("start_stop_stay_idle", 32'(pwm_onoff == PwmOn), 32'd0);

        // fault pulse while running
        start = 1; tick(); start = 0; run_n(5);
        fault = 1; tick(); fault = 0;
`ifdef PWM_FAULT_EN
        n = 1;
        while (pwm_onoff == PwmOn && n < 10) begin tick(); n++; end
        check("fault_off_edges", 32'(n), 32'd3);
        check("fault_active_set", 32'(fault_active), 32'd1);
        fault = 1; run_n(3);
        fault_clr = 1; tick(); fault_clr = 0; run_n(2);
        check("fault_clr_ignored", 32'(fault_active), 32'd1);
        fault = 0; run_n(3);
        fault_clr = 1; tick(); fault_clr = 0;
        check("fault_clr_exit", 32'(fault_active), 32'd0);
`else
        run_n(4);
        check("fault_ignored", 32'(pwm_onoff == PwmOn), 32'd1);
        check("fault_active_tied", 32'(fault_active), 32'd0);
        stop = 1; tick(); stop = 0;
        wait_off();
`endif

        // asynchronous reset mid-RUN, then start without a fresh write is ignored
        run_n(2);
        start = 1; tick(); start = 0; run_n(13);
        #2 reset = 1'b1;
        #1 model_reset();
        compare_all();
        check("async_rst_pwm", 32'(pwm), 32'd0);
        check("async_rst_onoff", 32'(pwm_onoff == PwmOff), 32'd1);
        check("async_rst_dtime_A", 32'(dtime_A), 32'd0);
        check("async_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        start = 1; tick(); start = 0; run_n(4);
        check("start_after_reset", 32'(pwm_onoff == PwmOn), 32'd0);

        // random traffic against the model
        cfg_write(8, 3, 1, 1);
        for (int i = 0; i < 900; i++) begin
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            cfg_valid  = ($urandom_range(0, 5) == 0);
            period_in  = CW'($urandom_range(0, 14));
            duty_in    = CW'($urandom_range(0, 16));
            dtime_A_in = DTW'($urandom_range(0, 7));
            dtime_B_in = DTW'($urandom_range(0, 7));
            fault      = ($urandom_range(0, 79) == 0);
            fault_clr  = ($urandom_range(0, 7) == 0);
            tick();
        end
        start = 0; stop = 0; cfg_valid = 0; fault = 0; fault_clr = 0;
        run_n(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
